// File: rtl/ising_run_controller.sv
// ising_run_controller
//   Sequences one anneal of the N-oscillator coupled-cell matrix. It holds the
//   pairwise weight register file, pulses the matrix oscillator reset, lets
//   the matrix free-run, then phase-samples every oscillator against
//   oscillator 0 and reports N spins.
//   Optional feature macro: ISING_ABORT_EN adds an `abort` input that cancels
//   a run in progress. Without it, a run always completes.
module ising_run_controller #(
  parameter int N             = 3,
  parameter int NUM_WEIGHTS   = 5,
  parameter int RST_CYCLES    = 4,
  parameter int RUN_CYCLES    = 64,
  parameter int SAMPLE_CYCLES = 16,
  parameter int P             = N * (N - 1) / 2,
  parameter int WW            = (NUM_WEIGHTS > 2) ? $clog2(NUM_WEIGHTS) : 1,
  parameter int AW            = (P > 1) ? $clog2(P) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_valid,
  output logic            wr_ready,
  input  logic [AW-1:0]   wr_addr,
  input  logic [WW-1:0]   wr_data,
  output logic            wr_err,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic [N-1:0]    spins,
  output logic            matrix_rstn,
  output logic [P*WW-1:0] weights_flat,
  input  logic [N-1:0]    matrix_out
`ifdef ISING_ABORT_EN
  ,
  input  logic            abort
`endif
);

  localparam int MAXP = (RUN_CYCLES > RST_CYCLES) ?
                        ((RUN_CYCLES > SAMPLE_CYCLES) ? RUN_CYCLES : SAMPLE_CYCLES) :
                        ((RST_CYCLES > SAMPLE_CYCLES) ? RST_CYCLES : SAMPLE_CYCLES);
  localparam int CW = $clog2(MAXP + 1);
  localparam int SW = $clog2(SAMPLE_CYCLES + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RST    = 3'd1;
  localparam logic [2:0] S_RUN    = 3'd2;
  localparam logic [2:0] S_SAMPLE = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [AW:0]   P_L      = (AW + 1)'(P);
  localparam logic [WW:0]   NW_L     = (WW + 1)'(NUM_WEIGHTS);
  localparam logic [WW-1:0] WMAX_L   = WW'(NUM_WEIGHTS - 1);
  localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] RUN_LAST = CW'(RUN_CYCLES - 1);
  localparam logic [CW-1:0] SMP_LAST = CW'(SAMPLE_CYCLES - 1);
  localparam logic [SW-1:0] HALF_L   = SW'(SAMPLE_CYCLES / 2);

  // Out-of-range weight values saturate at the highest coupling level.
  function automatic logic [WW-1:0] clamp_weight(input logic [WW-1:0] d);
    if ({1'b0, d} >= NW_L) begin
      clamp_weight = WMAX_L;
    end else begin
      clamp_weight = d;
    end
  endfunction

  logic [2:0]      state_r;
  logic [2:0]      state_next_s;
  logic [CW-1:0]   cnt_r;
  logic [N-1:0]    sync1_r;
  logic [N-1:0]    sync2_r;
  logic [SW-1:0]   agree_r     [N];
  logic [SW-1:0]   agree_tot_s [N];
  logic [N-1:0]    spins_r;
  logic [P*WW-1:0] weights_r;
  logic            wr_fire_s;
  logic            addr_ok_s;
  logic            start_go_s;
  logic            abort_s;
  logic            done_r;
  logic            busy_r;
  logic            wr_ready_r;
  logic            wr_err_r;
  logic            rstn_r;

`ifdef ISING_ABORT_EN
  assign abort_s = abort;
`else
  assign abort_s = 1'b0;
`endif

  assign wr_fire_s  = wr_valid && (state_r == S_IDLE);
  assign addr_ok_s  = ({1'b0, wr_addr} < P_L);
  assign start_go_s = start && (state_r == S_IDLE);

  // Two-flop synchronizer for the free-running oscillator outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= '0;
      sync2_r <= '0;
    end else begin
      sync1_r <= matrix_out;
      sync2_r <= sync1_r;
    end
  end

  // Next-state decode; abort only cancels the three active phases.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) state_next_s = S_RST;
        else       state_next_s = S_IDLE;
      end
      S_RST: begin
        if (abort_s)                state_next_s = S_IDLE;
        else if (cnt_r == RST_LAST) state_next_s = S_RUN;
        else                        state_next_s = S_RST;
      end
      S_RUN: begin
        if (abort_s)                state_next_s = S_IDLE;
        else if (cnt_r == RUN_LAST) state_next_s = S_SAMPLE;
        else                        state_next_s = S_RUN;
      end
      S_SAMPLE: begin
        if (abort_s)                state_next_s = S_IDLE;
        else if (cnt_r == SMP_LAST) state_next_s = S_DONE;
        else                        state_next_s = S_SAMPLE;
      end
      S_DONE:  state_next_s = S_IDLE;
      default: state_next_s = S_IDLE;
    endcase
  end

  // Agreement totals including the current sample, used on the final window cycle.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      if (sync2_r[i] == sync2_r[0]) begin
        agree_tot_s[i] = agree_r[i] + SW'(1);
      end else begin
        agree_tot_s[i] = agree_r[i];
      end
    end
  end

  // State, phase counter and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= S_IDLE;
      cnt_r      <= '0;
      done_r     <= 1'b0;
      busy_r     <= 1'b0;
      wr_ready_r <= 1'b1;
      rstn_r     <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      cnt_r      <= (state_next_s != state_r) ? '0 : cnt_r + CW'(1);
      done_r     <= (state_next_s == S_DONE);
      busy_r     <= (state_next_s != S_IDLE);
      wr_ready_r <= (state_next_s == S_IDLE);
      rstn_r     <= (state_next_s == S_RUN) || (state_next_s == S_SAMPLE);
    end
  end

  // Phase agreement counting and the majority decision at the end of the window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) agree_r[i] <= '0;
      spins_r <= '0;
    end else if (state_r == S_RUN && state_next_s == S_SAMPLE) begin
      for (int i = 0; i < N; i++) agree_r[i] <= '0;
    end else if (state_r == S_SAMPLE) begin
      for (int i = 0; i < N; i++) agree_r[i] <= agree_tot_s[i];
      if (state_next_s == S_DONE) begin
        for (int i = 0; i < N; i++) spins_r[i] <= (agree_tot_s[i] > HALF_L);
      end
    end
  end

  // Weight file writes (IDLE only) and the sticky bad-address flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      weights_r <= '0;
      wr_err_r  <= 1'b0;
    end else begin
      if (wr_fire_s && addr_ok_s) begin
        for (int k = 0; k < P; k++) begin
          if (wr_addr == AW'(k)) weights_r[k*WW +: WW] <= clamp_weight(wr_data);
        end
      end
      if (wr_fire_s && !addr_ok_s) begin
        wr_err_r <= 1'b1;
      end else if (start_go_s) begin
        wr_err_r <= 1'b0;
      end
    end
  end

  assign wr_ready     = wr_ready_r;
  assign wr_err       = wr_err_r;
  assign busy         = busy_r;
  assign done         = done_r;
  assign spins        = spins_r;
  assign matrix_rstn  = rstn_r;
  assign weights_flat = weights_r;

endmodule

// File: tb/tb_ising_run_controller.sv
// Directed bench for ising_run_controller with a spin scoreboard.
module tb_ising_run_controller;

  localparam int N  = 3;
  localparam int P  = 3;
  localparam int WW = 3;
  localparam int AW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            wr_valid;
  logic            wr_ready;
  logic [AW-1:0]   wr_addr;
  logic [WW-1:0]   wr_data;
  logic            wr_err;
  logic            start;
  logic            busy;
  logic            done;
  logic [N-1:0]    spins;
  logic            matrix_rstn;
  logic [P*WW-1:0] weights_flat;
  logic [N-1:0]    matrix_out;
  logic            abort;

  int checks = 0;
  int errors = 0;
  logic [N-1:0]    exp_q [$];
  logic [P*WW-1:0] exp_w;
  logic [N-1:0]    last_spins;

  ising_run_controller dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_err(wr_err), .start(start),
    .busy(busy), .done(done), .spins(spins), .matrix_rstn(matrix_rstn),
    .weights_flat(weights_flat), .matrix_out(matrix_out)
`ifdef ISING_ABORT_EN
    , .abort(abort)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [WW-1:0] d);
    wr_valid = 1'b1; wr_addr = a; wr_data = d;
    if (a < AW'(P)) exp_w[a*WW +: WW] = (d >= 3'd5) ? 3'd4 : d;
    step();
    wr_valid = 1'b0;
    chk("weights_write", weights_flat, exp_w);
  endtask

  // One full anneal: start, then cycle-by-cycle expectations for 100 cycles.
  task automatic run_anneal(input logic [N-1:0] mo, input bit toggle, input bit interfere);
    logic [N-1:0] exp_s;
    logic [N-1:0] got;
    exp_s[0] = 1'b1;
    for (int i = 1; i < N; i++) exp_s[i] = (mo[i] == mo[0]);
    if (toggle) exp_s[1] = 1'b0;
    exp_q.push_back(exp_s);
    matrix_out = mo;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("wr_err_cleared", wr_err, 32'd0);
    for (int k = 1; k <= 100; k++) begin
      chk("matrix_rstn", matrix_rstn, (k >= 5 && k <= 84) ? 32'd1 : 32'd0);
      chk("done", done, (k == 85) ? 32'd1 : 32'd0);
      chk("busy", busy, (k <= 85) ? 32'd1 : 32'd0);
      if (done) begin
        if (exp_q.size() == 0) begin
          chk("sb_extra_done", done, 32'd0);
        end else begin
          got = exp_q.pop_front();
          chk("spins", spins, got);
          last_spins = got;
        end
      end
      if (interfere && k == 40) chk("spins_hold", spins, last_spins);
      if (toggle) matrix_out[1] = k[0];
      start = interfere && (k == 20);
      if (interfere && k == 75) begin
        chk("wr_ready_busy", wr_ready, 32'd0);
        wr_valid = 1'b1; wr_addr = 2'd0; wr_data = 3'd1;
      end else begin
        wr_valid = 1'b0;
      end
      step();
    end
    chk("weights_after_run", weights_flat, exp_w);
    chk("spins_stable", spins, last_spins);
  endtask

  initial begin
    rst = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; matrix_out = '0; abort = 1'b0;
    exp_w = '0; last_spins = '0;
    step(); step();
    rst = 1'b0;
    step();
    chk("rst_spins", spins, 32'd0);
    chk("rst_done", done, 32'd0);
    chk("rst_rstn", matrix_rstn, 32'd0);
    chk("rst_weights", weights_flat, 32'd0);
    chk("rst_wr_ready", wr_ready, 32'd1);
    chk("rst_wr_err", wr_err, 32'd0);
    chk("rst_busy", busy, 32'd0);

    wr(2'd0, 3'd2);
    wr(2'd1, 3'd4);
    wr(2'd2, 3'd7);
    chk("weights_clamped", weights_flat, 32'h122);

    wr(2'd3, 3'd5);
    chk("bad_addr_err", wr_err, 32'd1);

    run_anneal(3'b011, 1'b0, 1'b0);
    run_anneal(3'b101, 1'b1, 1'b1);
    run_anneal(3'b110, 1'b0, 1'b0);

`ifdef ISING_ABORT_EN
    wr(2'd0, 3'd3);
    matrix_out = 3'b000;
    start = 1'b1; step(); start = 1'b0;
    for (int k = 1; k < 14; k++) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_busy", busy, 32'd0);
    chk("abort_rstn", matrix_rstn, 32'd0);
    chk("abort_spins", spins, last_spins);
    chk("abort_weights", weights_flat, exp_w);
    for (int k = 0; k < 100; k++) begin
      chk("abort_no_done", done, 32'd0);
      step();
    end
`endif

    start = 1'b1; step(); start = 1'b0;
    for (int k = 1; k < 30; k++) step();
    rst = 1'b1;
    #1;
    exp_w = '0; last_spins = '0;
    chk("midrst_busy", busy, 32'd0);
    chk("midrst_rstn", matrix_rstn, 32'd0);
    chk("midrst_weights", weights_flat, exp_w);
    chk("midrst_spins", spins, last_spins);
    chk("midrst_wr_ready", wr_ready, 32'd1);
    step();
    rst = 1'b0;
    for (int k = 0; k < 100; k++) begin
      chk("midrst_no_done", done, 32'd0);
      step();
    end
    chk("sb_drained", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
